nr4sdp_serial_decoder: RTL



---
 rtl/nr4sdp_serial_decoder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/nr4sdp_serial_decoder.sv
// Serial MSB-first decoder for a 16-bit NR4SD+ recoded operand (7 NR4SD+ digits
// plus a top Modified-Booth digit) back to two's complement, 1 or 2 digits/clock.
module nr4sdp_serial_decoder #(
  parameter int unsigned DPC = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  nm,
  input  logic [6:0]  np,
  input  logic        sign,
  input  logic        one,
  input  logic        two,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] result,
  output logic        ovf,
  output logic        err
);

  localparam int unsigned ND = 7;
  localparam int unsigned W  = 16;
  localparam int unsigned AW = 18;
  localparam int unsigned CW = 3;
  localparam logic signed [AW-1:0] MAX_V = 18'sd32767;
  localparam logic signed [AW-1:0] MIN_V = -18'sd32768;

  if (DPC != 1 && DPC != 2) begin : g_bad_dpc
    $error("nr4sdp_serial_decoder: DPC must be 1 or 2");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state;
  logic [ND-1:0]         nm_r;
  logic [ND-1:0]         np_r;
  logic                  err_q;
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;

  logic signed [AW-1:0]  d7_c;
  logic signed [AW-1:0]  d_hi_c;
  logic signed [AW-1:0]  d_lo_c;
  logic signed [AW-1:0]  acc_step_c;
  logic [CW-1:0]         cnt_lo_c;
  logic [CW-1:0]         cnt_step_c;
  logic                  dbl_c;
  logic                  ovf_c;

  // NR4SD+ digit value 2*np - nm, in {-1,0,1,2}
  function automatic logic signed [AW-1:0] nr_digit(input logic n, input logic p);
    logic signed [AW-1:0] d;
    d = '0;
    if (p) d = d + 18'sd2;
    if (n) d = d - 18'sd1;
    return d;
  endfunction

  // Top MB digit; the illegal one=two=1 code contributes zero
  always_comb begin
    d7_c = '0;
    if (one ^ two) begin
      d7_c = one ? 18'sd1 : 18'sd2;
      if (sign) d7_c = -d7_c;
    end
  end

  // Horner step: one digit, or two when DPC=2 and at least two digits remain
  always_comb begin
    cnt_lo_c   = (cnt == '0) ? '0 : cnt - CW'(1);
    dbl_c      = (DPC == 2) && (cnt != '0);
    d_hi_c     = nr_digit(nm_r[cnt], np_r[cnt]);
    d_lo_c     = nr_digit(nm_r[cnt_lo_c], np_r[cnt_lo_c]);
    acc_step_c = (acc <<< 2) + d_hi_c;
    cnt_step_c = cnt_lo_c;
    if (dbl_c) begin
      acc_step_c = (acc <<< 4) + (d_hi_c <<< 2) + d_lo_c;
      cnt_step_c = cnt - CW'(2);
    end
    ovf_c = (acc_step_c > MAX_V) || (acc_step_c < MIN_V);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      err       <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      nm_r      <= '0;
      np_r      <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            nm_r     <= nm;
            np_r     <= np;
            err_q    <= one & two;
            acc      <= d7_c;
            cnt      <= CW'(ND - 1);
            in_ready <= 1'b0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          acc <= acc_step_c;
          cnt <= cnt_step_c;
          if (cnt == '0) begin
            result    <= acc_step_c[W-1:0];
            ovf       <= ovf_c;
            err       <= err_q;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
